// File: rtl/xm_dmem_arbiter_pkg.sv
// Shared constants and types for the X/M data-memory arbiter.
// Optional feature macro: XM_DMEM_ARB_SAMELOAD_EN (see xm_dmem_arbiter.sv).
package xm_dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 12;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned OPC_W       = 5;

  localparam logic [OPC_W-1:0] OPC_SW = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_LW = 5'b01000;

  typedef enum logic {
    ST_IDLE,
    ST_SECOND
  } arb_state_e;

  // Which slot's load result arrives on dmem_q in the following cycle.
  typedef enum logic [1:0] {
    ROUTE_NONE,
    ROUTE_TOP,
    ROUTE_BOT,
    ROUTE_BOTH
  } route_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_mem;
  } mem_op_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/xm_dmem_arbiter_if.sv
// Pipeline-side and memory-side signals of the X/M data-memory arbiter.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface xm_dmem_arbiter_if
  import xm_dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic [INSTR_W-1:0] instruction_top;
  logic [INSTR_W-1:0] instruction_bot;
  logic               valid_top;
  logic               valid_bot;
  logic [ADDR_W-1:0]  addr_top;
  logic [ADDR_W-1:0]  addr_bot;
  logic [DATA_W-1:0]  wdata_top;
  logic [DATA_W-1:0]  wdata_bot;
  logic               pipe_hold;
  logic [DATA_W-1:0]  dmem_q;
  logic [ADDR_W-1:0]  dmem_address;
  logic [DATA_W-1:0]  dmem_data;
  logic               dmem_wren;
  logic               arb_stall;
  logic [DATA_W-1:0]  q_top;
  logic [DATA_W-1:0]  q_bot;

  modport slave (
    input  instruction_top, instruction_bot, valid_top, valid_bot,
    input  addr_top, addr_bot, wdata_top, wdata_bot, pipe_hold, dmem_q,
    output dmem_address, dmem_data, dmem_wren, arb_stall, q_top, q_bot
  );

  modport master (
    output instruction_top, instruction_bot, valid_top, valid_bot,
    output addr_top, addr_bot, wdata_top, wdata_bot, pipe_hold, dmem_q,
    input  dmem_address, dmem_data, dmem_wren, arb_stall, q_top, q_bot
  );

endinterface

// File: rtl/xm_dmem_arbiter_decode.sv
// Per-slot memory-op decode: load / store / any memory op, gated by slot valid.
module xm_mem_op_decode
  import xm_dmem_arbiter_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             valid,
  output mem_op_t          op_c
);

  always_comb begin
    op_c          = '0;
    op_c.is_load  = valid && (opcode == OPC_LW);
    op_c.is_store = valid && (opcode == OPC_SW);
    op_c.is_mem   = op_c.is_load || op_c.is_store;
  end

endmodule

// File: rtl/xm_dmem_arbiter.sv
// Single-port data-memory arbiter for the dual-issue X/M stage: serialises
// top-then-bottom on a dual memory op and returns load data aligned to M/W.
// Optional: XM_DMEM_ARB_SAMELOAD_EN merges two loads to the same address.
module xm_dmem_arbiter
  import xm_dmem_arbiter_pkg::*;
(
  input logic           clock,
  input logic           reset_n,
  xm_dmem_arbiter_if.slave bus
);

  mem_op_t op_top_c;
  mem_op_t op_bot_c;

  xm_mem_op_decode u_dec_top (
    .opcode (opcode_of(bus.instruction_top)),
    .valid  (bus.valid_top),
    .op_c   (op_top_c)
  );

  xm_mem_op_decode u_dec_bot (
    .opcode (opcode_of(bus.instruction_bot)),
    .valid  (bus.valid_bot),
    .op_c   (op_bot_c)
  );

  // Only the opcode field of each instruction matters here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instruction_top[INSTR_W-OPC_W-1:0],
                               bus.instruction_bot[INSTR_W-OPC_W-1:0]};

  logic same_load_c;
  logic conflict_c;

`ifdef XM_DMEM_ARB_SAMELOAD_EN
  assign same_load_c = op_top_c.is_load && op_bot_c.is_load &&
                       (bus.addr_top == bus.addr_bot);
`else
  assign same_load_c = 1'b0;
`endif

  assign conflict_c = op_top_c.is_mem && op_bot_c.is_mem && !same_load_c;

  arb_state_e             state_q,    state_d;
  route_e                 route_q,    route_d;
  logic                   top_held_q, top_held_d;
  logic                   reissue_q,  reissue_d;
  logic [DMEM_DATA_W-1:0] hold_top_q, hold_top_d;

  logic drive_c;
  logic sel_bot_c;
  logic stall_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      route_q    <= ROUTE_NONE;
      top_held_q <= 1'b0;
      reissue_q  <= 1'b0;
      hold_top_q <= '0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      top_held_q <= top_held_d;
      reissue_q  <= reissue_d;
      hold_top_q <= hold_top_d;
    end
  end

  // Next state, memory owner and load-result routing.
  always_comb begin
    state_d    = state_q;
    route_d    = ROUTE_NONE;
    top_held_d = 1'b0;
    reissue_d  = 1'b0;
    hold_top_d = hold_top_q;
    drive_c    = 1'b0;
    sel_bot_c  = 1'b0;
    stall_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (conflict_c) begin
          drive_c = 1'b1;
          stall_c = 1'b1;
          route_d = op_top_c.is_load ? ROUTE_TOP : ROUTE_NONE;
          // A held X/M register keeps re-issuing the top access.
          if (!bus.pipe_hold) begin
            state_d = ST_SECOND;
          end
        end else if (op_top_c.is_mem) begin
          drive_c = 1'b1;
          if (same_load_c) begin
            route_d = ROUTE_BOTH;
          end else begin
            route_d = op_top_c.is_load ? ROUTE_TOP : ROUTE_NONE;
          end
        end else if (op_bot_c.is_mem) begin
          drive_c   = 1'b1;
          sel_bot_c = 1'b1;
          route_d   = op_bot_c.is_load ? ROUTE_BOT : ROUTE_NONE;
        end
      end

      ST_SECOND: begin
        drive_c   = 1'b1;
        sel_bot_c = 1'b1;
        route_d   = op_bot_c.is_load ? ROUTE_BOT : ROUTE_NONE;
        reissue_d = bus.pipe_hold;
        // Top's data lands on dmem_q only in the first SECOND cycle.
        if (!reissue_q) begin
          hold_top_d = bus.dmem_q;
          top_held_d = (route_q == ROUTE_TOP);
        end else begin
          top_held_d = top_held_q;
        end
        if (!bus.pipe_hold) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.arb_stall = stall_c;

  assign bus.dmem_address = !drive_c  ? '0 :
                            sel_bot_c ? bus.addr_bot : bus.addr_top;
  assign bus.dmem_data    = !drive_c  ? '0 :
                            sel_bot_c ? bus.wdata_bot : bus.wdata_top;
  assign bus.dmem_wren    = drive_c &&
                            (sel_bot_c ? op_bot_c.is_store : op_top_c.is_store);

  // Steer last cycle's read data; a completed pair shows top's captured word.
  always_comb begin
    bus.q_top = '0;
    bus.q_bot = '0;
    if ((route_q == ROUTE_TOP) || (route_q == ROUTE_BOTH)) begin
      bus.q_top = bus.dmem_q;
    end else if (top_held_q) begin
      bus.q_top = hold_top_q;
    end
    if ((route_q == ROUTE_BOT) || (route_q == ROUTE_BOTH)) begin
      bus.q_bot = bus.dmem_q;
    end
  end

endmodule

// File: tb/tb_xm_dmem_arbiter.sv
// Randomised scoreboard bench for xm_dmem_arbiter with a program-order memory model.
`timescale 1ns/1ps
module tb_xm_dmem_arbiter;
  import xm_dmem_arbiter_pkg::*;

  localparam int unsigned MEM_WORDS = 1 << DMEM_ADDR_W;
`ifdef XM_DMEM_ARB_SAMELOAD_EN
  localparam bit SAMELOAD = 1'b1;
`else
  localparam bit SAMELOAD = 1'b0;
`endif
  localparam logic [4:0] OPC_ADD = 5'b00000;

  typedef struct packed {
    logic [4:0]  opc_t;
    logic [4:0]  opc_b;
    logic        v_t;
    logic        v_b;
    logic [11:0] a_t;
    logic [11:0] a_b;
    logic [31:0] d_t;
    logic [31:0] d_b;
  } pair_t;

  typedef struct packed {
    logic [31:0] q_t;
    logic [31:0] q_b;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  xm_dmem_arbiter_if bus ();

  xm_dmem_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  exp_t mon_e;
  logic adv_pending;
  logic mw_valid;
  logic mem_load;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  function automatic logic [31:0] init_word(input int unsigned i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A00_00A5;
  endfunction

  // Single-port synchronous memory: read data one cycle after the address.
  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
    end else begin
      if (bus.dmem_wren) mem[bus.dmem_address] <= bus.dmem_data;
      bus.dmem_q <= mem[bus.dmem_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: a pair that left X/M on the last edge is in M/W now.
  always @(negedge clock) begin
    if (mw_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow at %0t: actual=empty required=entry", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("q_top", bus.q_top, mon_e.q_t);
        check("q_bot", bus.q_bot, mon_e.q_b);
      end
    end
    adv_pending = reset_n && !bus.arb_stall && !bus.pipe_hold;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) mw_valid <= 1'b0;
    else          mw_valid <= adv_pending;
  end

  task automatic drive_pair(input pair_t p);
    bus.instruction_top = {p.opc_t, 27'($urandom)};
    bus.instruction_bot = {p.opc_b, 27'($urandom)};
    bus.valid_top = p.v_t;
    bus.valid_bot = p.v_b;
    bus.addr_top  = p.a_t;
    bus.addr_bot  = p.a_b;
    bus.wdata_top = p.d_t;
    bus.wdata_bot = p.d_b;
  endtask

  task automatic drive_bubble();
    bus.valid_top = 1'b0;
    bus.valid_bot = 1'b0;
    bus.instruction_top = '0;
    bus.instruction_bot = '0;
    bus.addr_top = '0;
    bus.addr_bot = '0;
    bus.wdata_top = '0;
    bus.wdata_bot = '0;
  endtask

  // Present one instruction pair until it leaves X/M; checks the memory side each cycle.
  task automatic issue(input pair_t p, input logic [31:0] hold_mask);
    logic lt, lb, st, sb, mt, mb, conf, drv, use_b, done;
    exp_t e;
    int   stalls;
    lt   = p.v_t && (p.opc_t == OPC_LW);
    st   = p.v_t && (p.opc_t == OPC_SW);
    lb   = p.v_b && (p.opc_b == OPC_LW);
    sb   = p.v_b && (p.opc_b == OPC_SW);
    mt   = lt || st;
    mb   = lb || sb;
    conf = mt && mb && !(SAMELOAD && lt && lb && (p.a_t == p.a_b));
    if (conf) hold_mask[0] = 1'b0;
    // Program order: top completes before bottom observes memory.
    e.q_t = lt ? ref_mem[p.a_t] : 32'h0;
    if (st) ref_mem[p.a_t] = p.d_t;
    e.q_b = lb ? ref_mem[p.a_b] : 32'h0;
    if (sb) ref_mem[p.a_b] = p.d_b;
    exp_q.push_back(e);
    drive_pair(p);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.pipe_hold = (c < 32) ? hold_mask[c] : 1'b0;
      @(negedge clock);
      drv   = mt || mb;
      use_b = conf ? (c > 0) : !mt;
      check("dmem_address", 32'(bus.dmem_address),
            drv ? 32'(use_b ? p.a_b : p.a_t) : 32'h0);
      check("dmem_data", bus.dmem_data, drv ? (use_b ? p.d_b : p.d_t) : 32'h0);
      check("dmem_wren", 32'(bus.dmem_wren), 32'(drv && (use_b ? sb : st)));
      if (bus.arb_stall) stalls++;
      @(posedge clock);
      done = adv_pending;
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL advance_timeout at %0t: actual=stuck required=advance", $time);
    end
    check("stall_cycles", 32'(stalls), conf ? 32'd1 : 32'd0);
  endtask

  function automatic pair_t mk(input logic [4:0] ot, input logic [11:0] at, input logic [31:0] dt,
                               input logic [4:0] ob, input logic [11:0] ab, input logic [31:0] db);
    pair_t p;
    p.opc_t = ot; p.a_t = at; p.d_t = dt; p.v_t = 1'b1;
    p.opc_b = ob; p.a_b = ab; p.d_b = db; p.v_b = 1'b1;
    return p;
  endfunction

  function automatic logic [4:0] rand_opc();
    int unsigned r;
    r = $urandom_range(0, 2);
    if (r == 0) return OPC_LW;
    if (r == 1) return OPC_SW;
    return 5'($urandom);
  endfunction

  initial begin
    pair_t p;
    n_cmp = 0;
    n_bad = 0;
    adv_pending = 1'b0;
    mem_load = 1'b1;
    bus.pipe_hold = 1'b1;
    drive_bubble();
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

    repeat (2) @(posedge clock);
    #1;
    mem_load = 1'b0;
    check("rst_q_top", bus.q_top, 32'h0);
    check("rst_q_bot", bus.q_bot, 32'h0);
    check("rst_arb_stall", 32'(bus.arb_stall), 32'h0);
    check("rst_dmem_wren", 32'(bus.dmem_wren), 32'h0);
    check("rst_dmem_address", 32'(bus.dmem_address), 32'h0);
    check("rst_dmem_data", bus.dmem_data, 32'h0);
    reset_n = 1'b1;

    // Seed memory through the arbiter itself (dual stores serialise too).
    issue(mk(OPC_SW, 12'h010, 32'hDEAD_BEEF, OPC_SW, 12'h004, 32'h1111_1111), 32'h0);
    issue(mk(OPC_SW, 12'h008, 32'h2222_2222, OPC_SW, 12'h030, 32'h0BAD_F00D), 32'h0);
    // Single load beside an ALU op.
    issue(mk(OPC_LW, 12'h010, 32'h0, OPC_ADD, 12'h7FF, 32'h1234), 32'h0);
    // Dual load.
    issue(mk(OPC_LW, 12'h004, 32'h0, OPC_LW, 12'h008, 32'h0), 32'h0);
    // Store then load to the same address across slots.
    issue(mk(OPC_SW, 12'h020, 32'h5A5A_5A5A, OPC_LW, 12'h020, 32'h0), 32'h0);
    // Conflict held for two cycles in SECOND.
    issue(mk(OPC_LW, 12'h004, 32'h0, OPC_LW, 12'h008, 32'h0), 32'h0000_0006);

    // Reset while in SECOND with a hold in place.
    bus.pipe_hold = 1'b0;
    drive_pair(mk(OPC_LW, 12'h004, 32'h0, OPC_LW, 12'h008, 32'h0));
    @(posedge clock);
    #1;
    bus.pipe_hold = 1'b1;
    #2;
    check("second_arb_stall", 32'(bus.arb_stall), 32'h0);
    check("second_bot_addr", 32'(bus.dmem_address), 32'h008);
    reset_n = 1'b0;
    drive_bubble();
    #1;
    check("midrst_q_top", bus.q_top, 32'h0);
    check("midrst_q_bot", bus.q_bot, 32'h0);
    check("midrst_wren", 32'(bus.dmem_wren), 32'h0);
    check("midrst_address", 32'(bus.dmem_address), 32'h0);
    check("midrst_arb_stall", 32'(bus.arb_stall), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    issue(mk(OPC_LW, 12'h010, 32'h0, OPC_ADD, 12'h0, 32'h0), 32'h0);

    // Two loads to one address: merged or serialised depending on the build.
    issue(mk(OPC_LW, 12'h030, 32'h0, OPC_LW, 12'h030, 32'h0), 32'h0);
    // Bottom-only store and bottom-only load.
    issue(mk(OPC_ADD, 12'h0, 32'h0, OPC_SW, 12'h044, 32'hCAFE_0001), 32'h0);
    issue(mk(OPC_ADD, 12'h0, 32'h0, OPC_LW, 12'h044, 32'h0), 32'h1);

    for (int n = 0; n < 400; n++) begin
      p.opc_t = rand_opc();
      p.opc_b = rand_opc();
      p.v_t   = ($urandom_range(0, 9) != 0);
      p.v_b   = ($urandom_range(0, 9) != 0);
      p.a_t   = 12'($urandom_range(0, 23));
      p.a_b   = ($urandom_range(0, 3) == 0) ? p.a_t : 12'($urandom_range(0, 23));
      p.d_t   = $urandom;
      p.d_b   = $urandom;
      issue(p, $urandom & $urandom & 32'h0000_00FF);
    end

    bus.pipe_hold = 1'b1;
    drive_bubble();
    repeat (2) @(negedge clock);
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xm_dmem_arbiter.md
# xm_dmem_arbiter

Arbitrates the single-ported data memory between the top and bottom instructions of the dual-issue X/M stage. A conflict is both slots carrying a load or store in the same cycle. On a conflict the block stalls the front of the pipeline for one cycle and serialises the accesses in program order, top then bottom. It returns each slot's load data aligned to the M/W stage.

## Interface
- ADDR_W, 12: data-memory word address width
- DATA_W, 32: data width
- clock  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- instruction_top / instruction_bot  in  32  X/M instruction per slot; opcode = [31:27], store 00111, load 01000
- valid_top / valid_bot  in  1  slot holds a real instruction (not a bubble)
- addr_top / addr_bot  in  ADDR_W  ALU-computed memory address per slot
- wdata_top / wdata_bot  in  DATA_W  store data per slot
- pipe_hold  in  1  external stall; X/M register not advancing this cycle
- dmem_q  in  DATA_W  data-memory read data, valid the cycle after the address
- dmem_address  out  ADDR_W  memory address (combinational)
- dmem_data  out  DATA_W  memory write data (combinational)
- dmem_wren  out  1  memory write enable (combinational)
- arb_stall  out  1  hold PC, F/D, D/X and X/M; insert a bubble into M/W
- q_top / q_bot  out  DATA_W  load result for each slot while it is in M/W

## Operation
- Per-slot decode: mem = valid & (store | load). Conflict = mem_top & mem_bot.
- FSM states:
  - IDLE:
    - No memory op: address/data/wren = 0.
    - Exactly one memory op: that slot drives the memory; arb_stall = 0.
    - Conflict: top drives the memory; arb_stall = 1; next state SECOND.
  - SECOND:
    - Bottom drives the memory; arb_stall = 0.
    - If pipe_hold = 1: stay in SECOND and re-issue bottom.
    - Else: next state IDLE.
- dmem_wren = 1 only when the slot currently driving the memory is a store.
- Route register: captures which slot the current access belongs to, so the next cycle's dmem_q is steered to q_top or q_bot.
- The other q output: its held value when it is the held slot, else 0.
- hold_top: loads dmem_q at the end of the first SECOND cycle only. A pipe_hold re-issue never overwrites it.
- After a conflict, q_top = hold_top and q_bot = dmem_q. Both are valid in the same M/W cycle.
- Store-then-load to the same address across slots: serial order gives the load the new value. No forwarding is needed.
- pipe_hold in IDLE: no state change. Single accesses are re-issued; stores are idempotent.

## Timing
- Non-conflict: 0 extra cycles. Load data is visible in the cycle after issue (M/W).
- Conflict: exactly 1 stall cycle. Top issues in cycle N, bottom in N+1, both results appear in N+2.
- arb_stall is combinational from state and decode. It is never asserted in SECOND.
- Reset (asynchronous, any state, including mid-SECOND):
  - state = IDLE, route = none, hold_top = 0.
  - q_top = q_bot = 0.
  - The memory outputs are combinational from these values, so they are 0 while no valid memory op is present.
- A reset_n deassertion takes effect on the next rising edge. There is no partial replay of an interrupted pair.

## Configuration
- XM_DMEM_ARB_SAMELOAD_EN:
  - Defined: two loads to the same address are not a conflict. One access is issued, dmem_q feeds both q_top and q_bot, and there is no stall.
  - Undefined: every dual memory op, including identical loads, takes the serialised 1-stall path.

## Structure
- Shared package constants:
  - OPC_SW = 5'b00111, OPC_LW = 5'b01000
  - FSM state enum (IDLE, SECOND)
  - route encoding (NONE, TOP, BOT)
- One sub-module, xm_mem_op_decode: per-slot is_load / is_store / is_mem from opcode and valid. Instantiated twice.

## Test plan
- Single load (top lw, addr 0x010, mem[0x010] = 0xDEADBEEF; bot add) → arb_stall = 0; next cycle q_top = 0xDEADBEEF, q_bot = 0.
- Dual load (top addr 0x004 → 0x11111111, bot addr 0x008 → 0x22222222) → arb_stall = 1 for one cycle; two cycles later q_top = 0x11111111, q_bot = 0x22222222.
- Top sw 0x5A5A5A5A to 0x020, bot lw from 0x020 → wren high in cycle N only; q_bot = 0x5A5A5A5A.
- Conflict with pipe_hold = 1 for 2 cycles in SECOND → bottom is re-issued each cycle; hold_top is unchanged; final q_top/q_bot are correct.
- reset_n pulsed low mid-SECOND → outputs are 0 immediately; the FSM restarts in IDLE; a following single load completes normally.
- Two loads to 0x030 (mem = 0x0BADF00D): with the macro, no stall and both q = 0x0BADF00D; without it, 1 stall and both q = 0x0BADF00D.
